// File: rtl/memory_bus_pkg.sv
// Shared constants and helpers for the memory bus arbiter: channel-index sizing
// and the widths of the optional statistics counters.
package memory_bus_pkg;

  localparam int MAX_MASTERS       = 16;
  localparam int GRANT_COUNT_WIDTH = 32;
  localparam int DROP_COUNT_WIDTH  = 16;
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_COUNT_MAX = 16'hFFFF;

  // Wide enough for any legal channel index.
  typedef logic [$clog2(MAX_MASTERS)-1:0] chan_idx_t;

  // Bits needed to index MASTERS channels, never below one.
  function automatic int chan_index_width(input int masters);
    return (masters > 1) ? $clog2(masters) : 1;
  endfunction

endpackage

// File: rtl/memory_bus_if.sv
// MemoryBus: ms* carries requests master->slave, sm* carries responses back,
// each channel with its own valid/taken handshake.
interface MemoryBus #(
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MASTER_ID_WIDTH = 8
);

  logic [MASTER_ID_WIDTH-1:0] msID;
  logic [ADDRESS_WIDTH-1:0]   msAddress;
  logic [DATA_WIDTH-1:0]      msData;
  logic                       msWrite;
  logic                       msValid;
  logic                       msTaken;

  logic [MASTER_ID_WIDTH-1:0] smID;
  logic [DATA_WIDTH-1:0]      smData;
  logic                       smValid;
  logic                       smTaken;

  modport master (
    output msID, msAddress, msData, msWrite, msValid,
    input  msTaken,
    input  smID, smData, smValid,
    output smTaken
  );

  modport slave (
    input  msID, msAddress, msData, msWrite, msValid,
    output msTaken,
    output smID, smData, smValid,
    input  smTaken
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first requester strictly after ptr, wrapping,
// and returns it both one-hot and as an index.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Scan N candidates starting one past the pointer; first hit wins.
  always_comb begin
    grant  = '0;
    idx    = '0;
    found  = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 1; k <= N; k++) begin
      cand_s        = IW'((int'(ptr) + k) % N);
      hit_s         = en && !found && req[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      idx           = hit_s ? cand_s : idx;
      found         = found | hit_s;
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// Funnels MASTERS request channels onto one MemoryBus master port through a
// single register slot, and routes responses back by master ID.
// Optional statistics counters: define MEMORY_BUS_ARBITER_STATS_EN.
module memory_bus_arbiter
  import memory_bus_pkg::*;
#(
  parameter int MASTERS         = 4,
  parameter int DATA_WIDTH      = 24,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int MASTER_ID_WIDTH = 8,
  parameter int BASE_ID         = 0
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic [MASTERS-1:0][ADDRESS_WIDTH-1:0]   upAddress,
  input  logic [MASTERS-1:0][DATA_WIDTH-1:0]      upData,
  input  logic [MASTERS-1:0]                      upWrite,
  input  logic [MASTERS-1:0]                      upValid,
  output logic [MASTERS-1:0]                      upTaken,
  output logic [MASTERS-1:0][DATA_WIDTH-1:0]      upRespData,
  output logic [MASTERS-1:0]                      upRespValid,
  input  logic [MASTERS-1:0]                      upRespTaken,
`ifdef MEMORY_BUS_ARBITER_STATS_EN
  output logic [MASTERS-1:0][GRANT_COUNT_WIDTH-1:0] grantCount,
  output logic [DROP_COUNT_WIDTH-1:0]             dropCount,
`endif
  MemoryBus.master                                bus
);

  localparam int IW = chan_index_width(MASTERS);
  localparam logic [IW-1:0]              LAST_CHAN  = IW'(MASTERS - 1);
  localparam logic [MASTER_ID_WIDTH-1:0] BASE_ID_W  = MASTER_ID_WIDTH'(BASE_ID);
  localparam logic [MASTER_ID_WIDTH:0]   MASTERS_W  = (MASTER_ID_WIDTH + 1)'(MASTERS);

  logic                       slot_valid_r;
  logic [MASTER_ID_WIDTH-1:0] slot_id_r;
  logic [ADDRESS_WIDTH-1:0]   slot_addr_r;
  logic [DATA_WIDTH-1:0]      slot_data_r;
  logic                       slot_write_r;
  logic [IW-1:0]              ptr_r;

  logic                       accept_s;
  logic                       arb_en_s;
  logic [MASTERS-1:0]         grant_s;
  logic [IW-1:0]              grant_idx_s;
  logic                       grant_any_s;

  logic [MASTER_ID_WIDTH-1:0] resp_off_s;
  logic                       resp_hit_s;
  logic [IW-1:0]              resp_idx_s;

  // The slot takes a new request when empty or draining this very cycle;
  // grants are suppressed while in reset or flushing.
  assign accept_s = !slot_valid_r || bus.msTaken;
  assign arb_en_s = accept_s && !flush && reset;

  rr_arbiter #(
    .N  (MASTERS),
    .IW (IW)
  ) u_rr (
    .req   (upValid),
    .en    (arb_en_s),
    .ptr   (ptr_r),
    .grant (grant_s),
    .idx   (grant_idx_s),
    .found (grant_any_s)
  );

  assign upTaken = grant_s;

  // Request slot and round-robin pointer; pointer moves only on a grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_valid_r <= 1'b0;
      slot_id_r    <= '0;
      slot_addr_r  <= '0;
      slot_data_r  <= '0;
      slot_write_r <= 1'b0;
      ptr_r        <= LAST_CHAN;
    end else if (flush) begin
      slot_valid_r <= 1'b0;
      ptr_r        <= LAST_CHAN;
    end else if (accept_s) begin
      slot_valid_r <= grant_any_s;
      if (grant_any_s) begin
        ptr_r        <= grant_idx_s;
        slot_id_r    <= BASE_ID_W + MASTER_ID_WIDTH'(grant_idx_s);
        slot_addr_r  <= upAddress[grant_idx_s];
        slot_data_r  <= upData[grant_idx_s];
        slot_write_r <= upWrite[grant_idx_s];
      end else begin
        ptr_r <= ptr_r;
      end
    end else begin
      slot_valid_r <= slot_valid_r;
    end
  end

  assign bus.msValid   = slot_valid_r;
  assign bus.msID      = slot_id_r;
  assign bus.msAddress = slot_addr_r;
  assign bus.msData    = slot_data_r;
  assign bus.msWrite   = slot_write_r;

  // Response routing; IDs below BASE_ID wrap high and so fall out of range.
  assign resp_off_s = bus.smID - BASE_ID_W;
  assign resp_hit_s = ({1'b0, resp_off_s} < MASTERS_W);
  assign resp_idx_s = resp_off_s[IW-1:0];
  assign upRespData = {MASTERS{bus.smData}};

  // Steer valid to the addressed channel and its taken back; drop strays.
  always_comb begin
    upRespValid = '0;
    bus.smTaken = 1'b1;
    if (resp_hit_s) begin
      upRespValid[resp_idx_s] = bus.smValid;
      bus.smTaken             = upRespTaken[resp_idx_s];
    end else begin
      upRespValid = '0;
      bus.smTaken = 1'b1;
    end
  end

`ifdef MEMORY_BUS_ARBITER_STATS_EN
  logic [MASTERS-1:0][GRANT_COUNT_WIDTH-1:0] grant_count_r;
  logic [DROP_COUNT_WIDTH-1:0]               drop_count_r;
  logic                                      drop_s;

  assign drop_s = bus.smValid && !resp_hit_s;

  // Grant counters wrap; the drop counter sticks at its maximum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_count_r <= '0;
      drop_count_r  <= '0;
    end else if (flush) begin
      grant_count_r <= '0;
      drop_count_r  <= '0;
    end else begin
      for (int i = 0; i < MASTERS; i++) begin
        if (grant_s[i]) begin
          grant_count_r[i] <= grant_count_r[i] + 32'd1;
        end else begin
          grant_count_r[i] <= grant_count_r[i];
        end
      end
      if (drop_s && (drop_count_r != DROP_COUNT_MAX)) begin
        drop_count_r <= drop_count_r + 16'd1;
      end else begin
        drop_count_r <= drop_count_r;
      end
    end
  end

  assign grantCount = grant_count_r;
  assign dropCount  = drop_count_r;
`endif

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: a scoreboard queue of expected bus
// requests driven from a round-robin reference, plus response-routing checks.
module tb_memory_bus_arbiter;

  localparam int M      = 4;
  localparam int BASE_A = 0;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [23:0] data;
    logic        wr;
  } req_t;

  logic clock = 1'b0;
  logic reset;
  logic flush;

  logic [M-1:0][31:0] up_address;
  logic [M-1:0][23:0] up_data;
  logic [M-1:0]       up_write;
  logic [M-1:0]       up_valid;
  logic [M-1:0]       up_taken;
  logic [M-1:0][23:0] up_resp_data;
  logic [M-1:0]       up_resp_valid;
  logic [M-1:0]       up_resp_taken;

  logic [M-1:0][31:0] b_address = '0;
  logic [M-1:0][23:0] b_data    = '0;
  logic [M-1:0]       b_write   = '0;
  logic [M-1:0]       b_valid   = '0;
  logic [M-1:0]       b_taken;
  logic [M-1:0][23:0] b_resp_data;
  logic [M-1:0]       b_resp_valid;
  logic [M-1:0]       b_resp_taken;

`ifdef MEMORY_BUS_ARBITER_STATS_EN
  logic [M-1:0][31:0] grant_count_a;
  logic [15:0]        drop_count_a;
  logic [M-1:0][31:0] grant_count_b;
  logic [15:0]        drop_count_b;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_ptr    = M - 1;
  req_t sb_q[$];

  MemoryBus #(.DATA_WIDTH(24), .ADDRESS_WIDTH(32), .MASTER_ID_WIDTH(8)) bus_a ();
  MemoryBus #(.DATA_WIDTH(24), .ADDRESS_WIDTH(32), .MASTER_ID_WIDTH(8)) bus_b ();

  memory_bus_arbiter #(
    .MASTERS(M), .DATA_WIDTH(24), .ADDRESS_WIDTH(32), .MASTER_ID_WIDTH(8), .BASE_ID(BASE_A)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .upAddress   (up_address),
    .upData      (up_data),
    .upWrite     (up_write),
    .upValid     (up_valid),
    .upTaken     (up_taken),
    .upRespData  (up_resp_data),
    .upRespValid (up_resp_valid),
    .upRespTaken (up_resp_taken),
`ifdef MEMORY_BUS_ARBITER_STATS_EN
    .grantCount  (grant_count_a),
    .dropCount   (drop_count_a),
`endif
    .bus         (bus_a)
  );

  memory_bus_arbiter #(
    .MASTERS(M), .DATA_WIDTH(24), .ADDRESS_WIDTH(32), .MASTER_ID_WIDTH(8), .BASE_ID(8)
  ) dut_b (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .upAddress   (b_address),
    .upData      (b_data),
    .upWrite     (b_write),
    .upValid     (b_valid),
    .upTaken     (b_taken),
    .upRespData  (b_resp_data),
    .upRespValid (b_resp_valid),
    .upRespTaken (b_resp_taken),
`ifdef MEMORY_BUS_ARBITER_STATS_EN
    .grantCount  (grant_count_b),
    .dropCount   (drop_count_b),
`endif
    .bus         (bus_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare the bus slot against the scoreboard head, retire it on handshake,
  // then predict this cycle's grant and queue the request it will produce.
  task automatic check_cycle();
    req_t       head;
    logic       exp_valid;
    logic       can;
    logic       found;
    logic [1:0] ci;
    logic [M-1:0] exp_grant;
    exp_valid = (sb_q.size() != 0);
    chk("msValid", bus_a.msValid, exp_valid);
    if (exp_valid) begin
      head = sb_q[0];
      chk("msID", bus_a.msID, head.id);
      chk("msAddress", bus_a.msAddress, head.addr);
      chk("msData", bus_a.msData, head.data);
      chk("msWrite", bus_a.msWrite, head.wr);
      if (bus_a.msTaken) head = sb_q.pop_front();
    end
    can       = !exp_valid || bus_a.msTaken;
    exp_grant = '0;
    found     = 1'b0;
    if (reset && !flush && can) begin
      for (int k = 1; k <= M; k++) begin
        ci = 2'((m_ptr + k) % M);
        if (!found && up_valid[ci]) begin
          found         = 1'b1;
          exp_grant[ci] = 1'b1;
          m_ptr         = int'(ci);
          sb_q.push_back('{id: 8'(BASE_A + int'(ci)), addr: up_address[ci],
                           data: up_data[ci], wr: up_write[ci]});
        end
      end
    end
    chk("upTaken", up_taken, exp_grant);
    if (flush) begin
      sb_q.delete();
      m_ptr = M - 1;
    end
  endtask

  task automatic step();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < M; i++) begin
      up_address[i] = 32'h1000_0000 + 32'(i * 16);
      up_data[i]    = 24'hA0_0000 + 24'(i);
    end
    up_write      = 4'b0101;
    up_valid      = 4'b1111;
    up_resp_taken = 4'b0000;
    b_resp_taken  = 4'b0000;
    bus_a.msTaken = 1'b1;
    bus_a.smID    = 8'd0;
    bus_a.smData  = 24'd0;
    bus_a.smValid = 1'b0;
    bus_b.msTaken = 1'b1;
    bus_b.smID    = 8'd0;
    bus_b.smData  = 24'd0;
    bus_b.smValid = 1'b0;
    #2 reset = 1'b0;

    // Reset held with every channel requesting: nothing granted, slot clear.
    repeat (2) step();
    chk("rst_msID", bus_a.msID, 8'd0);
    chk("rst_msAddress", bus_a.msAddress, 32'd0);
    chk("rst_msData", bus_a.msData, 24'd0);

    // All four requesting with no backpressure: 0,1,2,3,0,1.
    reset = 1'b1;
    repeat (6) step();

    // Three cycles of backpressure with the slot full, then release.
    bus_a.msTaken = 1'b0;
    repeat (3) step();
    bus_a.msTaken = 1'b1;
    step();

    // Sparse requesters with new payloads, then idle drain.
    up_valid   = 4'b1010;
    up_data[1] = 24'h11_1111;
    up_data[3] = 24'h33_3333;
    up_write   = 4'b1010;
    repeat (3) step();
    up_valid = 4'b0000;
    repeat (2) step();
    up_valid = 4'b0010;
    step();

    // Flush with ch2 last granted and the slot stalled; ch0 must follow.
    up_valid = 4'b0100;
    step();
    bus_a.msTaken = 1'b0;
    up_valid      = 4'b1111;
    flush         = 1'b1;
    step();
    flush         = 1'b0;
    bus_a.msTaken = 1'b1;
    repeat (2) step();

    // Asynchronous reset mid-request with the slot full.
    bus_a.msTaken = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("rst_async_msValid", bus_a.msValid, 1'b0);
    chk("rst_async_upTaken", up_taken, 4'b0000);
    sb_q.delete();
    m_ptr = M - 1;
    step();
    reset         = 1'b1;
    bus_a.msTaken = 1'b1;
    repeat (2) step();
    up_valid = 4'b0000;
    step();
`ifdef MEMORY_BUS_ARBITER_STATS_EN
    chk("grantCount0", grant_count_a[0], 32'd1);
    chk("grantCount1", grant_count_a[1], 32'd1);
    chk("grantCount2", grant_count_a[2], 32'd0);
`endif

    // Response routed to channel 2, following its taken.
    bus_a.smID    = 8'd2;
    bus_a.smData  = 24'h5A_5A5A;
    bus_a.smValid = 1'b1;
    up_resp_taken = 4'b0000;
    #1;
    chk("resp_taken_lo", bus_a.smTaken, 1'b0);
    chk("resp_valid_ch2", up_resp_valid, 4'b0100);
    for (int i = 0; i < M; i++) chk("resp_data_bcast", up_resp_data[i], 24'h5A_5A5A);
    up_resp_taken = 4'b0100;
    #1;
    chk("resp_taken_hi", bus_a.smTaken, 1'b1);
    chk("resp_valid_ch2_b", up_resp_valid, 4'b0100);
    step();
    up_resp_taken = 4'b1011;
    bus_a.smData  = 24'hC3_0F00;
    #1;
    chk("resp_taken_other", bus_a.smTaken, 1'b0);
    chk("resp_data_ch0", up_resp_data[0], 24'hC3_0F00);
    bus_a.smID = 8'd7;
    #1;
    chk("resp_oor_taken", bus_a.smTaken, 1'b1);
    chk("resp_oor_valid", up_resp_valid, 4'b0000);
    bus_a.smValid = 1'b0;
    bus_a.smID    = 8'd1;
    #1;
    chk("resp_idle_valid", up_resp_valid, 4'b0000);
    step();

    // Second instance at BASE_ID 8: ID 3 is dropped, ID 9 reaches ch1.
    bus_b.smID    = 8'd3;
    bus_b.smValid = 1'b1;
    #1;
    chk("b_drop_taken", bus_b.smTaken, 1'b1);
    chk("b_drop_valid", b_resp_valid, 4'b0000);
    step();
    bus_b.smValid = 1'b0;
`ifdef MEMORY_BUS_ARBITER_STATS_EN
    chk("b_dropCount", drop_count_b, 16'd1);
`endif
    bus_b.smID    = 8'd9;
    bus_b.smValid = 1'b1;
    b_resp_taken  = 4'b0010;
    #1;
    chk("b_route_valid", b_resp_valid, 4'b0010);
    chk("b_route_taken", bus_b.smTaken, 1'b1);
    b_resp_taken = 4'b0000;
    #1;
    chk("b_route_taken_lo", bus_b.smTaken, 1'b0);
    bus_b.smValid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_bus_arbiter.md
MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

Interface
REQ-001 Parameter MASTERS, default 4, number of upstream master channels (2..16).
REQ-002 Parameter DATA_WIDTH, default 24, bus data width.
REQ-003 Parameter ADDRESS_WIDTH, default 32, bus address width.
REQ-004 Parameter MASTER_ID_WIDTH, default 8, bus master-ID width.
REQ-005 Parameter BASE_ID, default 0, channel i owns bus ID BASE_ID+i; BASE_ID+MASTERS-1 SHALL fit MASTER_ID_WIDTH.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 flush  input  1  synchronous clear of request stage and round-robin pointer.
REQ-009 upAddress/upData/upWrite/upValid  input  [MASTERS] x ADDRESS_WIDTH/DATA_WIDTH/1/1  per-channel request.
REQ-010 upTaken  output  [MASTERS] x 1  per-channel request accept.
REQ-011 upRespData/upRespValid  output  [MASTERS] x DATA_WIDTH/1  per-channel response.
REQ-012 upRespTaken  input  [MASTERS] x 1  per-channel response accept.
REQ-013 bus  MemoryBus interface port  DATA_WIDTH/ADDRESS_WIDTH/MASTER_ID_WIDTH  single downstream master port (ms*/sm* signals).

Function
REQ-014 Every handshake SHALL transfer on a cycle where valid and taken are both high; valid SHALL NOT depend combinationally on taken.
REQ-015 Request stage SHALL be one register slot driving bus.msID/msAddress/msData/msWrite/msValid.
REQ-016 Slot SHALL accept a new request when empty or when bus.msValid && bus.msTaken in the same cycle (full throughput, 1 req/cycle).
REQ-017 When slot can accept, arbiter SHALL grant exactly one valid channel, round-robin starting at (last granted + 1) mod MASTERS, asserting that channel's upTaken combinationally that cycle.
REQ-018 Granted request SHALL appear on bus.ms* the next cycle (latency 1), with msID forced to BASE_ID+granted index.
REQ-019 Round-robin pointer SHALL update only on a grant; with no valid channel, slot empties and pointer holds.
REQ-020 Response path SHALL be combinational: idx = bus.smID - BASE_ID; if idx < MASTERS, upRespValid[idx]=bus.smValid, upRespData[idx]=bus.smData, bus.smTaken=upRespTaken[idx].
REQ-021 Response with idx out of range SHALL be dropped: bus.smTaken=1, no upRespValid asserted.
REQ-022 All non-addressed upRespValid SHALL be 0; upRespData SHALL broadcast bus.smData.
REQ-023 flush SHALL, next edge, empty the slot, set pointer to MASTERS-1 (so channel 0 is next), and force all upTaken low during the flush cycle; response path unaffected.
REQ-024 Simultaneous slot drain and refill SHALL lose no request and duplicate none.

Reset
REQ-025 reset low SHALL asynchronously clear slot (msValid=0), msID/msAddress/msData/msWrite=0, pointer=MASTERS-1.
REQ-026 During reset all upTaken=0; combinational response outputs follow REQ-020..022.
REQ-027 Release of reset SHALL be synchronised externally; block SHALL grant no earlier than the first edge after release.

Configuration
REQ-028 Macro MEMORY_BUS_ARBITER_STATS_EN defined: adds outputs grantCount [MASTERS] x 32 (per-channel grants, wrap at 2^32) and dropCount 16 (dropped responses, saturating at 65535), both cleared by reset and flush.
REQ-029 Macro undefined: these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-030 Package memory_bus_pkg SHALL hold channel-index typedef width function ($clog2(MASTERS)) and the counter width constants.
REQ-031 Round-robin selection SHALL be sub-module rr_arbiter (request vector, enable, pointer in; one-hot grant, index out).

Verification
REQ-032 Reset: reset low mid-request with slot full -> msValid=0 immediately, upTaken all 0; after release ch0 requests first.
REQ-033 All 4 channels valid, msTaken held 1 -> grants ch0,1,2,3,0 on consecutive cycles, msID 0,1,2,3,0 one cycle later.
REQ-034 msTaken=0 for 3 cycles with slot full -> msAddress stable, no upTaken; on msTaken=1 next grant same cycle.
REQ-035 smID=BASE_ID+2, smValid=1, upRespTaken[2]=0 then 1 -> smTaken follows 0 then 1, only upRespValid[2] high.
REQ-036 BASE_ID=8, smID=3 -> smTaken=1, no upRespValid; with STATS_EN dropCount=1.
REQ-037 flush while slot full and ch2 last granted -> msValid=0 next cycle, next grant ch0.
